tree_adder_seq: RTL and testbench

- Sequences a pipelined, fully registered adder tree over a multi-chunk dot-product reduction.
- Accepts NUM_CHUNKS input chunks from an upstream source via valid/ready and strobes each one into the external tree.
- Tracks in-flight chunks with a tag pipeline matched to the tree depth and accumulates each tree result.
- Presents the final reduced value to the downstream layer logic via valid/ready; sits between the ternary-multiply vector stage and the activation stage.

---
 rtl/tree_adder_seq.sv | 102 ++++++++++
 tb/tb_tree_adder_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tree_adder_seq.sv
// Sequencer for an external, fully registered adder tree: issues NUM_CHUNKS chunks, tracks them with a tag pipeline, accumulates the tree results.
// Build option: define TREE_ADDER_SEQ_SAT_EN to saturate acc_out instead of wrapping it.
module tree_adder_seq #(
  parameter int TREE_LATENCY = 12,
  parameter int NUM_CHUNKS   = 16,
  parameter int SUM_W        = 20,
  parameter int ACC_W        = 26,
  parameter int OUT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    tree_launch,
  input  logic signed [SUM_W-1:0] tree_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] acc_out,
  output logic [1:0]              state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and acc_out holds while out_valid is 1 and out_ready is 0.

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state, state_nx;
  logic [CNT_W-1:0]         cnt;
  logic [TREE_LATENCY-1:0]  tag;
  logic signed [ACC_W-1:0]  acc;
  logic                     last_chunk;

  assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (tree_launch && last_chunk) state_nx = S_DRAIN;
      S_DRAIN: if (tag == '0) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    in_ready    = (state == S_ISSUE);
    tree_launch = in_valid & (state == S_ISSUE);
    out_valid   = (state == S_DONE);
    state_dbg   = state;
  end

  // The tag pipeline mirrors the tree: tag[TREE_LATENCY-1] marks a valid tree_sum this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tag <= '0;
      acc <= '0;
    end else begin
      tag <= TREE_LATENCY'({tag, tree_launch});
      if (state == S_IDLE && start) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        if (tree_launch) cnt <= cnt + 1'b1;
        if (tag[TREE_LATENCY-1])
          acc <= acc + {{(ACC_W-SUM_W){tree_sum[SUM_W-1]}}, tree_sum};
      end
    end
  end

`ifdef TREE_ADDER_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (acc > SAT_MAX)      acc_out = {1'b0, {(OUT_W-1){1'b1}}};
    else if (acc < SAT_MIN) acc_out = {1'b1, {(OUT_W-1){1'b0}}};
    else                    acc_out = acc[OUT_W-1:0];
  end
`else
  always_comb begin
    acc_out = acc[OUT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_tree_adder_seq.sv
// Bench for tree_adder_seq with a behavioural 12-stage tree model and an expected-result queue.
module tb_tree_adder_seq;

  localparam int L      = 12;
  localparam int N      = 4;
  localparam int SUM_W  = 20;
  localparam int ACC_W  = 26;
  localparam int OUT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic                    tree_launch;
  logic signed [SUM_W-1:0] tree_sum;
  logic signed [SUM_W-1:0] chunk_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        acc_out;
  logic [1:0]              state_dbg;

  logic [OUT_W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int cyc = 0;
  int last_launch = 0;
  int launch_cnt = 0;
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  tree_adder_seq #(
    .TREE_LATENCY(L), .NUM_CHUNKS(N), .SUM_W(SUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .tree_launch(tree_launch),
    .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .state_dbg(state_dbg)
  );

  // clock / reset-independent tree model and cycle bookkeeping
  always #5 clk = ~clk;

  logic signed [SUM_W-1:0] tree_pipe [L];
  always @(posedge clk) begin
    for (int k = L - 1; k > 0; k--) tree_pipe[k] <= tree_pipe[k-1];
    tree_pipe[0] <= tree_launch ? chunk_sum : SUM_W'($urandom);
  end
  assign tree_sum = tree_pipe[L-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tree_launch) begin
      last_launch <= cyc + 1;
      launch_cnt  <= launch_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] conv(input int s);
`ifdef TREE_ADDER_SEQ_SAT_EN
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
`endif
    return s[OUT_W-1:0];
  endfunction

  // driver: one full reduction. gap_mode 0=in_valid high, 1=fixed gap pattern, 2=random
  task automatic run_red(input int s0, input int s1, input int s2, input int s3,
                         input int gap_mode, input int stall,
                         input bit start_in_issue, input bit start_at_hs);
    int sums[4];
    int idx;
    int pi;
    int guard;
    int lc0;
    sums = '{s0, s1, s2, s3};
    exp_q.push_back(conv(s0 + s1 + s2 + s3));
    lc0 = launch_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; pi = 0; guard = 0;
    while (idx < N && guard < 200) begin
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (pat[pi % 7] != 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      chunk_sum = SUM_W'(sums[idx]);
      pi++;
      if (start_in_issue && pi == 2) start = 1'b1;
      #1;
      if (tree_launch) idx++;
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    check("issue_done", idx, N);
    in_valid  = (gap_mode == 0);
    chunk_sum = SUM_W'(12345);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("out_valid_seen", out_valid, 1);
    check("latency", cyc - last_launch, L + 1);
    check("launches", launch_cnt - lc0, N);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", acc_out, exp_q[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (start_at_hs) start = 1'b1;
    #1;
    if (out_valid && exp_q.size() > 0) check("acc_out", acc_out, exp_q.pop_front());
    else check("handshake_ready", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("busy_after", busy, 0);
    check("idle_after", state_dbg, 0);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b0; chunk_sum = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_launch", tree_launch, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    run_red(100, -50, 30, 20, 0, 0, 1'b0, 1'b0);
    run_red(5, 6, 7, 8, 1, 5, 1'b0, 1'b0);
    run_red(30000, 10000, 0, 0, 0, 0, 1'b0, 1'b0);
    run_red(-30000, -10000, 0, 0, 0, 2, 1'b0, 1'b0);

    // abort a reduction in DRAIN with results still in the tree
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    chunk_sum = SUM_W'(77777);
    repeat (N) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("drain_state", state_dbg, 2);
    in_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_launch", tree_launch, 0);
    check("mid_rst_acc_out", acc_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    run_red(1, 2, 3, 4, 0, 0, 1'b0, 1'b0);

    run_red(11, -22, 33, -44, 0, 1, 1'b1, 1'b1);
    run_red(-524288, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_red(524287, 524287, 524287, 524287, 2, 1, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      run_red($urandom_range(0, 1048575) - 524288, $urandom_range(0, 1048575) - 524288,
              $urandom_range(0, 1048575) - 524288, $urandom_range(0, 1048575) - 524288,
              2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
